lzc_share_sched: RTL and testbench
==================================

// Module: lzc_share_sched
// PURPOSE
//  Round-robin scheduler that shares one leading-zero/leading-one count datapath
//  between NUM_REQ requesters. Each requester presents an operand plus a mode bit
//  (0 = count leading zeros, 1 = count leading ones) over a valid/ready handshake.
//  Results return on one valid/ready response channel, tagged with the requester
//  ID. Two-stage pipeline: operand register S1, result register S2. Full throughput.
// PARAMETERS
//  NUM_REQ  4                    number of requesters, >=2
//  WI_SZ    32                   operand width; power of two, >=2
//  WO_SZ    $clog2(WI_SZ)+1      count width; holds 0..WI_SZ
//  ID_W     $clog2(NUM_REQ)      requester ID width
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              asynchronous active-high reset
//  req_valid  in   NUM_REQ        per-requester request valid
//  req_ready  out  NUM_REQ        per-requester accept; at most one bit set
//  req_data   in   NUM_REQ*WI_SZ  operands; requester i at [i*WI_SZ +: WI_SZ]
//  req_mode   in   NUM_REQ        per-requester mode: 0 = CLZ, 1 = CLO
//  rsp_valid  out  1              result valid
//  rsp_ready  in   1              downstream accepts result
//  rsp_count  out  WO_SZ          leading zero/one count, 0..WI_SZ
//  rsp_id     out  ID_W           index of the requester that owns the result
//  rsp_mode   out  1              mode the result was computed in
// BEHAVIOUR
//  Reset (async assert; state is used from the first edge after deassert):
//   - S1/S2 valid = 0, rr_ptr = 0.
//   - rsp_valid = 0; rsp_count, rsp_id, rsp_mode = 0.
//   - req_ready = 0 while rst is high.
//   - Reset mid-operation drops in-flight S1/S2 contents; nothing is replayed.
//  Arbitration:
//   - grant is one-hot, combinational from req_valid and rr_ptr only.
//   - Grant goes to the first valid index at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
//   - grant never depends on rsp_ready or req_ready (no comb loop).
//   - s2_free = !S2.valid | rsp_ready; s1_free = !S1.valid | s2_free.
//   - req_ready[i] = grant[i] & s1_free.
//   - Accept = req_valid[i] & req_ready[i]. On accept, rr_ptr <= (i+1) mod NUM_REQ.
//   - Without an accept, rr_ptr holds.
//  Pipeline:
//   - On accept, S1 loads {data, mode, id}.
//   - S1 -> S2 when S1.valid & s2_free. S2 gets count = CLZ(data) for mode 0,
//     CLZ(~data) for mode 1.
//   - S1 clears when it drains and no new accept occurs in the same cycle.
//   - Simultaneous drain and accept is legal: S1 reloads, no bubble.
//   - S2 holds its result stable while rsp_valid & !rsp_ready.
//  Latency and throughput:
//   - Accept on edge N gives rsp_valid from edge N+1 when S2 is free.
//   - Throughput is one result per cycle with rsp_ready held high.
//  Arithmetic:
//   - Count is MSB-first.
//   - All-zero data in CLZ, or all-ones data in CLO -> rsp_count = WI_SZ
//     (MSB of rsp_count set, other bits 0).
//   - MSB differs from the counted value -> rsp_count = 0.
//  Boundaries:
//   - Back-pressure with rsp_ready low: S2 fills, then S1 fills, then all
//     req_ready = 0. No result is lost or duplicated.
//   - A requester holding req_valid unaccepted keeps its data stable.
//   - Fairness: a continuously valid requester is granted within NUM_REQ accepts.
//   - All req_valid = 0: no accept, rr_ptr holds, pipeline drains normally.
// TESTING
//  T1 reset: rst=1 mid-traffic with S1, S2 full -> rsp_valid=0, req_ready=0,
//     rr_ptr=0 after release; first grant goes to the lowest valid index.
//  T2 arithmetic, WI_SZ=32:
//     CLZ 0x0001_0000 -> 15; CLZ 0 -> 32; CLZ 0x8000_0000 -> 0;
//     CLO 0xFFFF_FFFF -> 32; CLO 0xF0FF_FFFF -> 4.
//  T3 round-robin: all 4 valid continuously, rsp_ready=1 -> rsp_id 0,1,2,3,0,...
//     one per cycle, no bubbles.
//  T4 back-pressure: rsp_ready=0 for 10 cycles with 4 valid -> exactly 2 accepts,
//     then req_ready=0; release -> results in accept order, none lost or duplicated.
//  T5 sparse wrap: only req 3 and req 1 valid, rr_ptr=2 -> grant 3, then 1, then 3.
//     Single requester valid every cycle -> accepted every cycle.
//  T6 random: random valid/ready/data/mode for 10k cycles -> scoreboard vs
//     reference CLZ/CLO model, per-ID ordering, grant one-hot assertion.

Source files
------------

// File: rtl/lzc_share_sched.sv
// lzc_share_sched
//   Round-robin scheduler sharing one leading-zero / leading-one count datapath
//   between NUM_REQ requesters. Two pipeline stages: S1 holds the accepted operand,
//   S2 holds the computed count and drives the response channel. It sustains one
//   result per cycle.
//
// Ports
//   i_clk        clock, all state on rising edge
//   i_rst        asynchronous active-high reset
//   i_req_valid  per-requester request valid
//   o_req_ready  per-requester accept, at most one bit set
//   i_req_data   operands, requester i at [i*WI_SZ +: WI_SZ]
//   i_req_mode   per-requester mode: 0 = count leading zeros, 1 = count leading ones
//   o_rsp_valid  result valid
//   i_rsp_ready  downstream accepts result
//   o_rsp_count  leading zero/one count, 0..WI_SZ
//   o_rsp_id     requester that owns the result
//   o_rsp_mode   mode the result was computed in

module lzc_share_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WI_SZ   = 32,
    parameter int unsigned WO_SZ   = $clog2(WI_SZ) + 1,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*WI_SZ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]         i_req_mode,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [WO_SZ-1:0]           o_rsp_count,
    output logic [ID_W-1:0]            o_rsp_id,
    output logic                       o_rsp_mode
);

    // (base + off) mod NUM_REQ; off is always below NUM_REQ
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    // MSB-first run length of the counted bit value; an all-matching word gives WI_SZ
    function automatic logic [WO_SZ-1:0] lead_count(input logic [WI_SZ-1:0] data,
                                                    input logic             mode);
        logic [WI_SZ-1:0] x;
        logic [WO_SZ-1:0] cnt;
        logic             done;
        x    = mode ? ~data : data;
        cnt  = WO_SZ'(WI_SZ);
        done = 1'b0;
        for (int unsigned i = 0; i < WI_SZ; i++) begin
            if (!done && x[WI_SZ-1-i]) begin
                cnt  = WO_SZ'(i);
                done = 1'b1;
            end
        end
        return cnt;
    endfunction

    // Arbiter state
    logic [ID_W-1:0]    r_rr_ptr;

    // Stage 1: accepted operand
    logic               r_s1_valid;
    logic [WI_SZ-1:0]   r_s1_data;
    logic               r_s1_mode;
    logic [ID_W-1:0]    r_s1_id;

    // Stage 2: computed result, drives the response channel
    logic               r_s2_valid;
    logic [WO_SZ-1:0]   r_s2_count;
    logic               r_s2_mode;
    logic [ID_W-1:0]    r_s2_id;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_grant_any;
    logic               w_s2_free;
    logic               w_s1_free;
    logic               w_accept;
    logic [WI_SZ-1:0]   w_sel_data;

    // Grant depends only on i_req_valid and r_rr_ptr, so ready never loops back into it
    always_comb begin
        w_grant     = '0;
        w_grant_id  = '0;
        w_grant_any = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_any && i_req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_grant[wrap_idx(r_rr_ptr, k)] = 1'b1;
                w_grant_id                     = wrap_idx(r_rr_ptr, k);
                w_grant_any                    = 1'b1;
            end
        end
    end

    assign w_s2_free   = !r_s2_valid || i_rsp_ready;
    assign w_s1_free   = !r_s1_valid || w_s2_free;
    assign o_req_ready = i_rst ? '0 : (w_grant & {NUM_REQ{w_s1_free}});
    assign w_accept    = w_grant_any && w_s1_free && !i_rst;
    assign w_sel_data  = i_req_data[32'(w_grant_id) * WI_SZ +: WI_SZ];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
        end
    end

    // S1 may drain and reload in the same cycle, so no bubble is inserted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_id    <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_sel_data;
            r_s1_mode  <= i_req_mode[w_grant_id];
            r_s1_id    <= w_grant_id;
        end else if (w_s2_free) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2 holds while the response is stalled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_count <= '0;
            r_s2_mode  <= 1'b0;
            r_s2_id    <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_count <= lead_count(r_s1_data, r_s1_mode);
                r_s2_mode  <= r_s1_mode;
                r_s2_id    <= r_s1_id;
            end
        end
    end

    assign o_rsp_valid = r_s2_valid;
    assign o_rsp_count = r_s2_count;
    assign o_rsp_id    = r_s2_id;
    assign o_rsp_mode  = r_s2_mode;

endmodule

// File: tb/tb_lzc_share_sched.sv
// Bench for lzc_share_sched: reset, count vectors, round-robin order, back-pressure,
// sparse wrap and a long random run against a queue-based reference model.

module tb_lzc_share_sched;

    localparam int NUM_REQ = 4;
    localparam int WI_SZ   = 32;
    localparam int WO_SZ   = 6;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WI_SZ-1:0] req_data;
    logic [NUM_REQ-1:0]       req_mode;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WO_SZ-1:0]         rsp_count;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_mode;

    always #5 clk = ~clk;

    lzc_share_sched #(
        .NUM_REQ (NUM_REQ),
        .WI_SZ   (WI_SZ),
        .WO_SZ   (WO_SZ),
        .ID_W    (ID_W)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_data  (req_data),
        .i_req_mode  (req_mode),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_count (rsp_count),
        .o_rsp_id    (rsp_id),
        .o_rsp_mode  (rsp_mode)
    );

    // Reference model: FIFO of results in flight (at most two). An entry becomes
    // visible on the response channel once it reaches the head, one edge after accept.
    typedef struct {
        int id;
        bit mode;
        int count;
        bit vis;
    } item_t;

    typedef struct {
        logic [WI_SZ-1:0] data;
        bit               mode;
        int               exp;
    } vec_t;

    item_t m_q[$];
    int    m_ptr;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int ref_count(input logic [WI_SZ-1:0] d, input bit mode);
        int n = 0;
        while (n < WI_SZ && d[WI_SZ-1-n] == mode) n++;
        return n;
    endfunction

    function automatic int ref_grant(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [WI_SZ-1:0] rand_word();
        int unsigned r = $urandom_range(0, WI_SZ - 1);
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'hFFFF_FFFF >> r;
            3:       return ~(32'hFFFF_FFFF >> r);
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ptr = 0;
    endtask

    // Called at posedge+1 after inputs are driven; checks, crosses one edge,
    // updates the model and returns at the next posedge+1.
    task automatic tick(output int acc, output bit dut_acc);
        int               g;
        bit               free;
        bit               exp_rv;
        logic [NUM_REQ-1:0] exp_ready;
        #2;
        g         = ref_grant(req_valid);
        free      = (m_q.size() < 2) || rsp_ready;
        exp_ready = (g >= 0 && free) ? NUM_REQ'(1 << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("grant_onehot", 64'($countones(req_ready) <= 1), 64'(1));
        exp_rv = (m_q.size() > 0) && m_q[0].vis;
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            check("rsp_count", 64'(rsp_count), 64'(m_q[0].count));
            check("rsp_id", 64'(rsp_id), 64'(m_q[0].id));
            check("rsp_mode", 64'(rsp_mode), 64'(m_q[0].mode));
        end
        acc     = (exp_ready != 0) ? g : -1;
        dut_acc = |(req_ready & req_valid);
        @(posedge clk);
        if (exp_rv && rsp_ready) void'(m_q.pop_front());
        if (m_q.size() > 0) m_q[0].vis = 1'b1;
        if (acc >= 0) begin
            item_t it;
            it.id    = acc;
            it.mode  = req_mode[acc];
            it.count = ref_count(req_data[acc*WI_SZ +: WI_SZ], req_mode[acc]);
            it.vis   = 1'b0;
            m_q.push_back(it);
            m_ptr = (acc + 1) % NUM_REQ;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[10];
        int   acc;
        bit   dacc;
        int   ids[$];
        int   accs[$];
        int   n_acc;

        tv[0] = '{32'h0001_0000, 1'b0, 15};
        tv[1] = '{32'h0000_0000, 1'b0, 32};
        tv[2] = '{32'h8000_0000, 1'b0, 0};
        tv[3] = '{32'hFFFF_FFFF, 1'b1, 32};
        tv[4] = '{32'hF0FF_FFFF, 1'b1, 4};
        tv[5] = '{32'h0000_0001, 1'b0, 31};
        tv[6] = '{32'h7FFF_FFFF, 1'b1, 0};
        tv[7] = '{32'hFFFF_FFFE, 1'b1, 31};
        tv[8] = '{32'hFFFF_FFFF, 1'b0, 0};
        tv[9] = '{32'h0000_0000, 1'b1, 0};

        // Power-on reset
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        req_mode  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_req_ready", 64'(req_ready), 64'(0));
        rst       = 1'b0;
        req_valid = '0;
        model_reset();

        // Count vectors, one requester at a time
        for (int k = 0; k < 10; k++) begin
            req_valid                            = NUM_REQ'(1 << (k % NUM_REQ));
            req_data[(k % NUM_REQ)*WI_SZ +: WI_SZ] = tv[k].data;
            req_mode[k % NUM_REQ]                = tv[k].mode;
            tick(acc, dacc);
            req_valid = '0;
            tick(acc, dacc);
            check("vec_valid", 64'(rsp_valid), 64'(1));
            check("vec_count", 64'(rsp_count), 64'(tv[k].exp));
            check("vec_id", 64'(rsp_id), 64'(k % NUM_REQ));
        end

        // Reset mid-traffic with both stages full
        req_valid = '1;
        req_data  = '1;
        req_mode  = '1;
        rsp_ready = 1'b0;
        repeat (3) tick(acc, dacc);
        rst = 1'b1;
        #2;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_rsp_count", 64'(rsp_count), 64'(0));
        check("midrst_rsp_id", 64'(rsp_id), 64'(0));
        check("midrst_rsp_mode", 64'(rsp_mode), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        check("midrst_hold_valid", 64'(rsp_valid), 64'(0));
        rst       = 1'b0;
        rsp_ready = 1'b1;
        model_reset();
        #1;
        check("postrst_first_grant", 64'(req_ready), 64'(4'b0001));

        // Round-robin with all valid: ids 0,1,2,3,0,... one per cycle
        for (int c = 0; c < 12; c++) begin
            tick(acc, dacc);
            if (acc >= 0) begin
                req_data[acc*WI_SZ +: WI_SZ] = rand_word();
                req_mode[acc]                = 1'($urandom_range(0, 1));
            end
            if (rsp_valid) ids.push_back(int'(rsp_id));
        end
        check("rr_result_count", 64'(ids.size()), 64'(11));
        for (int k = 0; k < ids.size(); k++) check("rr_order", 64'(ids[k]), 64'(k % NUM_REQ));

        // Back-pressure: drain, then stall with all valid
        req_valid = '0;
        repeat (3) tick(acc, dacc);
        req_valid = '1;
        rsp_ready = 1'b0;
        n_acc     = 0;
        for (int c = 0; c < 10; c++) begin
            tick(acc, dacc);
            if (dacc) n_acc++;
            if (acc >= 0) accs.push_back(acc);
        end
        check("bp_accepts", 64'(n_acc), 64'(2));
        check("bp_ready_low", 64'(req_ready), 64'(0));
        req_valid = '0;
        rsp_ready = 1'b1;
        ids.delete();
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) ids.push_back(int'(rsp_id));
            tick(acc, dacc);
        end
        check("bp_results", 64'(ids.size()), 64'(accs.size()));
        for (int k = 0; k < ids.size() && k < accs.size(); k++)
            check("bp_order", 64'(ids[k]), 64'(accs[k]));

        // Sparse wrap: rr_ptr to 2 via req 1, then 3 and 1 valid
        req_valid = 4'b0010;
        tick(acc, dacc);
        req_valid = 4'b1010;
        #1;
        check("wrap_grant3", 64'(req_ready), 64'(4'b1000));
        tick(acc, dacc);
        check("wrap_grant1", 64'(req_ready), 64'(4'b0010));
        tick(acc, dacc);
        check("wrap_grant3b", 64'(req_ready), 64'(4'b1000));
        tick(acc, dacc);

        // Single requester accepted every cycle
        req_valid = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            tick(acc, dacc);
            check("single_accept", 64'(dacc), 64'(1));
        end

        // Random traffic; an unaccepted valid request keeps its data
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(req_valid[i] && i != acc)) begin
                    req_valid[i]                 = ($urandom_range(0, 99) < 55);
                    req_data[i*WI_SZ +: WI_SZ]   = rand_word();
                    req_mode[i]                  = 1'($urandom_range(0, 1));
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 65);
            tick(acc, dacc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
